// File: rtl/MD_pkg.sv
// Shared MD widths plus the remote-position receive buffer entry format.
package MD_pkg;

  localparam int OFFSET_PKT_STRUCT_WIDTH = 81;
  localparam int GLOBAL_CELL_ID_WIDTH    = 4;
  localparam int NB_CELL_COUNT_WIDTH     = 4;
  localparam int NUM_REMOTE_DEST_NODES   = 3;

  localparam int POS_RX_DEPTH = 16;
  localparam int POS_RX_AFULL = 12;

  localparam int REMOTE_SLOT_WIDTH  = (NUM_REMOTE_DEST_NODES > 1) ? $clog2(NUM_REMOTE_DEST_NODES) : 1;
  localparam int GCID_WIDTH         = 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int LIFETIME_VEC_WIDTH = NUM_REMOTE_DEST_NODES * NB_CELL_COUNT_WIDTH;

  typedef struct packed {
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] offset_pkt;
    logic [GCID_WIDTH-1:0]              gcid;
    logic [NB_CELL_COUNT_WIDTH-1:0]     lifetime;
  } pos_rx_entry_t;

  localparam int POS_RX_ENTRY_WIDTH = $bits(pos_rx_entry_t);

endpackage

// File: rtl/pos_rx_fifo.sv
// Register-array first-word-fall-through FIFO; head is read combinationally
// from the array so a consumer can ack in the same cycle it sees valid.
module pos_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pos_remote_rx_buffer.sv
// Receive buffer for remote position packets feeding the ring extension node.
// Optional statistics counters are built when POS_RX_STATS_EN is defined.
module pos_remote_rx_buffer
  import MD_pkg::*;
#(
  parameter int DEPTH        = POS_RX_DEPTH,
  parameter int AFULL_THRESH = POS_RX_AFULL
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [REMOTE_SLOT_WIDTH-1:0]       i_local_slot,
  input  logic                               i_net_valid,
  output logic                               o_net_ready,
  input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0] i_net_offset_pkt,
  input  logic [GCID_WIDTH-1:0]              i_net_gcid,
  input  logic [LIFETIME_VEC_WIDTH-1:0]      i_net_lifetime,
  output logic [OFFSET_PKT_STRUCT_WIDTH-1:0] o_remote_offset_pkt,
  output logic [GCID_WIDTH-1:0]              o_remote_gcid,
  output logic                               o_remote_valid,
  output logic [NB_CELL_COUNT_WIDTH-1:0]     o_remote_lifetime,
  input  logic                               i_remote_ack,
  output logic                               o_almost_full,
  output logic [$clog2(DEPTH):0]             o_count,
  output logic [31:0]                        o_rx_pkt_cnt,
  output logic [31:0]                        o_rx_drop_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

  logic [NB_CELL_COUNT_WIDTH-1:0] slot_lifetime;
  logic                           accept;
  logic                           keep;
  logic                           pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  pos_rx_entry_t                  wr_entry;
  pos_rx_entry_t                  head_entry;

  // NOTE: default assigned before the loop so no path leaves slot_lifetime unassigned (no latch).
  always_comb begin
    slot_lifetime = '0;
    for (int k = 0; k < NUM_REMOTE_DEST_NODES; k++) begin
      if (i_local_slot == REMOTE_SLOT_WIDTH'(k))
        slot_lifetime = i_net_lifetime[k*NB_CELL_COUNT_WIDTH +: NB_CELL_COUNT_WIDTH];
    end
  end

  assign o_net_ready = ~fifo_full;
  assign accept      = i_net_valid & o_net_ready;
  assign keep        = accept & (slot_lifetime != '0);
  assign pop         = i_remote_ack & o_remote_valid;

  assign wr_entry = '{offset_pkt: i_net_offset_pkt, gcid: i_net_gcid, lifetime: slot_lifetime};

  pos_rx_fifo #(
    .WIDTH (POS_RX_ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

  // Head fields are zero while empty so the ring node never sees stale data.
  assign o_remote_valid      = ~fifo_empty;
  assign o_remote_offset_pkt = fifo_empty ? '0 : head_entry.offset_pkt;
  assign o_remote_gcid       = fifo_empty ? '0 : head_entry.gcid;
  assign o_remote_lifetime   = fifo_empty ? '0 : head_entry.lifetime;
  assign o_almost_full       = (o_count >= AFULL_CNT);

`ifdef POS_RX_STATS_EN
  logic drop;
  assign drop = accept & (slot_lifetime == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rx_pkt_cnt  <= '0;
      o_rx_drop_cnt <= '0;
    end else begin
      if (keep && (o_rx_pkt_cnt != '1))  o_rx_pkt_cnt  <= o_rx_pkt_cnt + 32'd1;
      if (drop && (o_rx_drop_cnt != '1)) o_rx_drop_cnt <= o_rx_drop_cnt + 32'd1;
    end
  end
`else
  assign o_rx_pkt_cnt  = '0;
  assign o_rx_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pos_remote_rx_buffer.sv
// Scoreboard bench for pos_remote_rx_buffer: model queue tracks expected FIFO
// contents; every cycle checks status, head and statistics outputs.
module tb_pos_remote_rx_buffer;
  import MD_pkg::*;

  localparam int DEPTH = POS_RX_DEPTH;
  localparam int AFULL = POS_RX_AFULL;
  localparam int PW    = OFFSET_PKT_STRUCT_WIDTH;
  localparam int NB    = NB_CELL_COUNT_WIDTH;
  localparam int SW    = REMOTE_SLOT_WIDTH;
  localparam int LVW   = LIFETIME_VEC_WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SW-1:0]    i_local_slot = '0;
  logic             i_net_valid = 1'b0;
  logic             o_net_ready;
  logic [PW-1:0]    i_net_offset_pkt = '0;
  logic [GCID_WIDTH-1:0] i_net_gcid = '0;
  logic [LVW-1:0]   i_net_lifetime = '0;
  logic [PW-1:0]    o_remote_offset_pkt;
  logic [GCID_WIDTH-1:0] o_remote_gcid;
  logic             o_remote_valid;
  logic [NB-1:0]    o_remote_lifetime;
  logic             i_remote_ack = 1'b0;
  logic             o_almost_full;
  logic [CW-1:0]    o_count;
  logic [31:0]      o_rx_pkt_cnt;
  logic [31:0]      o_rx_drop_cnt;

  pos_remote_rx_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_local_slot        (i_local_slot),
    .i_net_valid         (i_net_valid),
    .o_net_ready         (o_net_ready),
    .i_net_offset_pkt    (i_net_offset_pkt),
    .i_net_gcid          (i_net_gcid),
    .i_net_lifetime      (i_net_lifetime),
    .o_remote_offset_pkt (o_remote_offset_pkt),
    .o_remote_gcid       (o_remote_gcid),
    .o_remote_valid      (o_remote_valid),
    .o_remote_lifetime   (o_remote_lifetime),
    .i_remote_ack        (i_remote_ack),
    .o_almost_full       (o_almost_full),
    .o_count             (o_count),
    .o_rx_pkt_cnt        (o_rx_pkt_cnt),
    .o_rx_drop_cnt       (o_rx_drop_cnt)
  );

  always #5 clk = ~clk;

  pos_rx_entry_t sb[$];
  int unsigned   exp_pkt_cnt;
  int unsigned   exp_drop_cnt;
  int            n_vec;
  int            n_err;

  function automatic logic [NB-1:0] slot_of(input logic [LVW-1:0] lv, input logic [SW-1:0] s);
    logic [LVW-1:0] sh;
    if (int'(s) >= NUM_REMOTE_DEST_NODES) return '0;
    sh = lv >> (int'(s) * NB);
    return sh[NB-1:0];
  endfunction

  task automatic rand_pkt(output logic [PW-1:0] pkt, output logic [GCID_WIDTH-1:0] gcid);
    logic [95:0] r;
    r    = {$urandom, $urandom, $urandom};
    pkt  = r[PW-1:0];
    gcid = GCID_WIDTH'($urandom);
  endtask

  // Check all outputs against the model, then apply one cycle of stimulus.
  task automatic step(input logic v, input logic [PW-1:0] pkt, input logic [GCID_WIDTH-1:0] gcid,
                      input logic [LVW-1:0] lv, input logic [SW-1:0] slot, input logic ack,
                      output logic acc);
    pos_rx_entry_t exp_head;
    logic          pop;
    logic [NB-1:0] l;
    rst = 1'b0;
    i_net_valid = v; i_net_offset_pkt = pkt; i_net_gcid = gcid;
    i_net_lifetime = lv; i_local_slot = slot; i_remote_ack = ack;
    #1;
    exp_head = (sb.size() != 0) ? sb[0] : '0;
    n_vec++;
    if (o_count !== CW'(sb.size())) begin
      n_err++; $display("FAIL count: got %0d expected %0d", o_count, sb.size());
    end
    n_vec++;
    if (o_net_ready !== (sb.size() < DEPTH)) begin
      n_err++; $display("FAIL net_ready: got %0b expected %0b", o_net_ready, sb.size() < DEPTH);
    end
    n_vec++;
    if (o_almost_full !== (sb.size() >= AFULL)) begin
      n_err++; $display("FAIL almost_full: got %0b expected %0b", o_almost_full, sb.size() >= AFULL);
    end
    n_vec++;
    if (o_remote_valid !== (sb.size() != 0)) begin
      n_err++; $display("FAIL remote_valid: got %0b expected %0b", o_remote_valid, sb.size() != 0);
    end
    n_vec++;
    if ({o_remote_offset_pkt, o_remote_gcid, o_remote_lifetime} !== exp_head) begin
      n_err++; $display("FAIL head: got %0h expected %0h",
                        {o_remote_offset_pkt, o_remote_gcid, o_remote_lifetime}, exp_head);
    end
`ifdef POS_RX_STATS_EN
    n_vec++;
    if (o_rx_pkt_cnt !== exp_pkt_cnt) begin
      n_err++; $display("FAIL rx_pkt_cnt: got %0d expected %0d", o_rx_pkt_cnt, exp_pkt_cnt);
    end
    n_vec++;
    if (o_rx_drop_cnt !== exp_drop_cnt) begin
      n_err++; $display("FAIL rx_drop_cnt: got %0d expected %0d", o_rx_drop_cnt, exp_drop_cnt);
    end
`else
    n_vec++;
    if ((o_rx_pkt_cnt | o_rx_drop_cnt) !== 32'd0) begin
      n_err++; $display("FAIL stats_tied: got %0h/%0h expected 0/0", o_rx_pkt_cnt, o_rx_drop_cnt);
    end
`endif
    acc = v && (sb.size() < DEPTH);
    pop = ack && (sb.size() != 0);
    if (pop) void'(sb.pop_front());
    if (acc) begin
      l = slot_of(lv, slot);
      if (l != '0) begin
        sb.push_back('{offset_pkt: pkt, gcid: gcid, lifetime: l});
        exp_pkt_cnt++;
      end else begin
        exp_drop_cnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ack);
    logic a;
    step(1'b0, '0, '0, '0, '0, ack, a);
  endtask

  // Reset with a handshake in flight; it must be discarded.
  task automatic apply_reset();
    rst = 1'b1; i_net_valid = 1'b1; i_remote_ack = 1'b1;
    i_local_slot = 2'd0; i_net_lifetime = '1; i_net_offset_pkt = '1; i_net_gcid = '1;
    @(posedge clk); #1;
    rst = 1'b0; i_net_valid = 1'b0; i_remote_ack = 1'b0;
    sb.delete();
    exp_pkt_cnt = 0;
    exp_drop_cnt = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    idle(1'b0);
    idle(1'b1);
  endtask

  task automatic test_single();
    logic [PW-1:0] pkt; logic [GCID_WIDTH-1:0] g; logic [LVW-1:0] lv; logic a;
    apply_reset();
    rand_pkt(pkt, g);
    lv = '0; lv[NB +: NB] = 4'd5; lv[2*NB +: NB] = 4'd9;
    step(1'b1, pkt, g, lv, 2'd1, 1'b0, a);
    n_vec++;
    if (o_remote_lifetime !== 4'd5 || o_remote_offset_pkt !== pkt || o_remote_gcid !== g) begin
      n_err++; $display("FAIL single_head: got lt %0d gcid %0h expected lt 5 gcid %0h",
                        o_remote_lifetime, o_remote_gcid, g);
    end
    idle(1'b1);
    idle(1'b0);
  endtask

  task automatic test_drop();
    logic [PW-1:0] pkt; logic [GCID_WIDTH-1:0] g; logic [LVW-1:0] lv; logic a;
    apply_reset();
    rand_pkt(pkt, g);
    lv = '0; lv[0 +: NB] = 4'd3; lv[2*NB +: NB] = 4'd7;
    step(1'b1, pkt, g, lv, 2'd1, 1'b0, a);
    idle(1'b0);
`ifdef POS_RX_STATS_EN
    n_vec++;
    if (o_rx_drop_cnt !== 32'd1 || o_rx_pkt_cnt !== 32'd0) begin
      n_err++; $display("FAIL drop_stats: got drop %0d pkt %0d expected drop 1 pkt 0",
                        o_rx_drop_cnt, o_rx_pkt_cnt);
    end
`endif
    // Out-of-range slot selects nothing, so even an all-nonzero vector drops.
    step(1'b1, pkt, g, '1, 2'd3, 1'b0, a);
    idle(1'b0);
  endtask

  task automatic test_fill();
    logic [PW-1:0] pkt; logic [GCID_WIDTH-1:0] g; logic [LVW-1:0] lv; logic a;
    apply_reset();
    lv = '1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_pkt(pkt, g);
      step(1'b1, pkt, g, lv, 2'd2, 1'b0, a);
    end
    rand_pkt(pkt, g);
    step(1'b1, pkt, g, lv, 2'd2, 1'b0, a);
    step(1'b1, pkt, g, lv, 2'd2, 1'b1, a);
    step(1'b1, pkt, g, lv, 2'd2, 1'b0, a);
    n_vec++;
    if (a !== 1'b1 || o_count !== CW'(DEPTH)) begin
      n_err++; $display("FAIL held_pkt: got acc %0b count %0d expected acc 1 count %0d", a, o_count, DEPTH);
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
  endtask

  task automatic test_simultaneous();
    logic [PW-1:0] pkt; logic [GCID_WIDTH-1:0] g; logic a;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      rand_pkt(pkt, g);
      step(1'b1, pkt, g, '1, 2'd0, 1'b0, a);
    end
    for (int i = 0; i < 20; i++) begin
      rand_pkt(pkt, g);
      step(1'b1, pkt, g, '1, 2'd0, 1'b1, a);
    end
    n_vec++;
    if (o_count !== CW'(3)) begin
      n_err++; $display("FAIL simul_count: got %0d expected 3", o_count);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
  endtask

  task automatic test_ack_empty_reset();
    logic [PW-1:0] pkt; logic [GCID_WIDTH-1:0] g; logic a;
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 7; i++) begin
      rand_pkt(pkt, g);
      step(1'b1, pkt, g, '1, 2'd1, 1'b0, a);
    end
    apply_reset();
    n_vec++;
    if (o_count !== '0 || o_remote_valid !== 1'b0 || o_net_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset: got count %0d valid %0b ready %0b expected 0 0 1",
                        o_count, o_remote_valid, o_net_ready);
    end
    rand_pkt(pkt, g);
    step(1'b1, pkt, g, '1, 2'd1, 1'b0, a);
    idle(1'b1);
    idle(1'b0);
  endtask

  task automatic test_random();
    logic [PW-1:0] pkt; logic [GCID_WIDTH-1:0] g; logic [LVW-1:0] lv; logic a;
    logic v, ack;
    int sent;
    apply_reset();
    sent = 0;
    while (sent < 10000) begin
      rand_pkt(pkt, g);
      lv  = LVW'($urandom);
      v   = ($urandom_range(3) != 0);
      ack = (sb.size() != 0) && ($urandom_range(4) != 0);
      step(v, pkt, g, lv, SW'($urandom), ack, a);
      if (a) sent++;
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    n_vec++;
    if (o_remote_valid !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL random_drain: got valid %0b model %0d expected 0 0", o_remote_valid, sb.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_pkt_cnt = 0;
    exp_drop_cnt = 0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_drop();
    test_fill();
    test_simultaneous();
    test_ack_empty_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
